// File: rtl/cpu_seq_pkg.sv
// Shared types for the instruction-slot sequencer: state encoding and a
// default-width view of the special registers for trace/debug tooling.
package lib_cpu;

  localparam int SEQ_ROM_AW = 11;
  localparam int SEQ_DATA_W = 8;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } SEQ_STATE;

  typedef struct packed {
    logic [SEQ_ROM_AW-1:0] pc;
    logic [SEQ_ROM_AW-1:0] epc;
    logic                  intr_en;
    logic                  irr;
    logic                  w_busy;
    logic [SEQ_DATA_W-1:0] r_data;
  } SEQ_SPECIAL_REG;

endpackage

// File: rtl/cpu_seq_if.sv
// Byte I/O channel between the sequencer and its receive/transmit peripheral.
// master = sequencer side, slave = peripheral side.
interface cpu_seq_if #(
  parameter int DATA_W = 8
);
  logic              irr;
  logic [DATA_W-1:0] r_data;
  logic              w_busy;
  logic              ack;
  logic              w_req;
  logic [DATA_W-1:0] w_data;

  modport master (
    input  irr, r_data, w_busy,
    output ack, w_req, w_data
  );

  modport slave (
    output irr, r_data, w_busy,
    input  ack, w_req, w_data
  );
endinterface

// File: rtl/cpu_seq_phase_ctr.sv
// Slot phase counter: counts 0..PHASES-1 and wraps; frozen while hold=1.
module seq_phase_ctr #(
  parameter int PHASES = 4,
  parameter int PH_W   = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic hold,
  output logic last
);

  localparam logic [PH_W-1:0] PH_LAST = PH_W'(PHASES - 1);

  logic [PH_W-1:0] phase;

  assign last = (phase == PH_LAST);

  // Advance one phase per cycle unless held; wrap after the last phase.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase <= '0;
    end else if (!hold) begin
      phase <= last ? '0 : phase + 1'b1;
    end
  end

endmodule

// File: rtl/cpu_seq.sv
// Instruction-slot sequencer: paces execute results into the special
// registers once per slot, and stalls the slot while a transmit is blocked.
// Optional build macro: CPU_SEQ_INTR_EN enables interrupt vectoring at commit.
module cpu_seq
  import lib_cpu::*;
#(
  parameter int                ROM_AW   = 11,
  parameter int                PHASES   = 4,
  parameter int                DATA_W   = 8,
  parameter logic [ROM_AW-1:0] INTR_VEC = {{(ROM_AW-1){1'b0}}, 1'b1}
) (
  input  logic              clk,
  input  logic              reset,
  cpu_seq_if.master         io,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [ROM_AW-1:0] ex_pc,
  input  logic              ex_intr_en,
  input  logic              ex_ack,
  input  logic              ex_w_req,
  input  logic [DATA_W-1:0] ex_w_data,
  output logic              commit,
  output logic [ROM_AW-1:0] pc,
  output logic              intr_en,
  output logic              irr_q,
  output logic              w_busy_q,
  output logic [DATA_W-1:0] r_data_q,
  output logic [ROM_AW-1:0] epc
);

  localparam int PH_W = (PHASES > 1) ? $clog2(PHASES) : 1;

`ifdef CPU_SEQ_INTR_EN
  localparam bit INTR_ON = 1'b1;
`else
  localparam bit INTR_ON = 1'b0;
`endif

  SEQ_STATE state;
  logic     last;
  logic     hold;
  logic     commit_now;
  logic     tx_fire;
  logic     take_intr;

  seq_phase_ctr #(
    .PHASES (PHASES),
    .PH_W   (PH_W)
  ) u_phase (
    .clk   (clk),
    .reset (reset),
    .hold  (hold),
    .last  (last)
  );

  // Commit fires on the last RUN phase unless a transmit is blocked, or on
  // the cycle the transmitter frees up while stalled. Gated by reset so an
  // aborted slot never pulses.
  always_comb begin
    commit_now = 1'b0;
    if (reset) begin
      case (state)
        RUN:     commit_now = last && !(ex_w_req && io.w_busy);
        STALL:   commit_now = !io.w_busy;
        default: commit_now = 1'b0;
      endcase
    end
  end

  // Phase moves on mid-slot in RUN, and wraps to 0 on any commit.
  assign hold      = !(commit_now || (state == RUN && !last));
  // A stalled slot always carries a pending transmit, so its exit sends it.
  assign tx_fire   = commit_now && (ex_w_req || state == STALL);
  assign take_intr = INTR_ON && io.irr && intr_en;

  assign commit    = commit_now;
  assign io.w_req  = tx_fire;
  assign io.w_data = tx_fire ? ex_w_data : '0;
  assign io.ack    = commit_now && ex_ack;
  assign rom_addr  = pc;

  // Slot FSM: park in STALL while the transmitter is busy at the commit point.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= RUN;
    end else begin
      case (state)
        RUN:     if (last && ex_w_req && io.w_busy) state <= STALL;
        STALL:   if (!io.w_busy) state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

  // Special registers load from execute and the I/O inputs at commit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc       <= '0;
      intr_en  <= 1'b0;
      irr_q    <= 1'b0;
      w_busy_q <= 1'b0;
      r_data_q <= '0;
    end else if (commit_now) begin
      pc       <= take_intr ? INTR_VEC : ex_pc;
      intr_en  <= take_intr ? 1'b0 : ex_intr_en;
      irr_q    <= io.irr;
      w_busy_q <= io.w_busy;
      r_data_q <= io.r_data;
    end
  end

`ifdef CPU_SEQ_INTR_EN
  // Return address captured when a commit is diverted to the vector.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      epc <= '0;
    end else if (commit_now && take_intr) begin
      epc <= ex_pc;
    end
  end
`else
  assign epc = '0;
`endif

endmodule
